// File: rtl/issue_unit_if.sv
// Ready/issue handshake between the four dispatch queues and the issue scheduler.
// The scheduler takes the master modport; the queue side takes the slave modport.
interface issue_if;
  logic int_rdy;
  logic ldst_rdy;
  logic mult_rdy;
  logic div_rdy;
  logic int_issue;
  logic ldst_issue;
  logic mult_issue;
  logic div_issue;

  modport master (
    input  int_rdy, ldst_rdy, mult_rdy, div_rdy,
    output int_issue, ldst_issue, mult_issue, div_issue
  );

  modport slave (
    output int_rdy, ldst_rdy, mult_rdy, div_rdy,
    input  int_issue, ldst_issue, mult_issue, div_issue
  );
endinterface

// File: rtl/issue_unit.sv
// Issue scheduler: grants at most one ready queue head per cycle, keeps the single CDB
// conflict-free through a reservation shift register, and holds off the unpipelined divider.
module issue_unit #(
  parameter int INT_LAT   = 1,
  parameter int LDST_LAT  = 2,
  parameter int MULT_LAT  = 4,
  parameter int DIV_LAT   = 7,
  parameter int RSV_DEPTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  issue_if.master              bus,
  output logic                 div_busy,
  output logic [RSV_DEPTH-1:0] cdb_rsv
);

  localparam int CNT_W = $clog2(DIV_LAT + 1);

  logic [RSV_DEPTH-1:0] cdb_rsv_q, cdb_rsv_d;
  logic [CNT_W-1:0]     div_cnt_q, div_cnt_d;
  logic                 div_busy_q, div_busy_d;
  logic                 rr_ptr_q, rr_ptr_d;

  logic int_elig, ldst_elig, mult_elig, div_elig;
  logic int_grant, ldst_grant, mult_grant, div_grant;

  // A unit may issue only if the CDB slot its result will land in is still free.
  assign int_elig  = bus.int_rdy  & ~cdb_rsv_q[INT_LAT];
  assign ldst_elig = bus.ldst_rdy & ~cdb_rsv_q[LDST_LAT];
  assign mult_elig = bus.mult_rdy & ~cdb_rsv_q[MULT_LAT];
  assign div_elig  = bus.div_rdy  & ~cdb_rsv_q[DIV_LAT] & ~div_busy_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    div_grant  = 1'b0;
    mult_grant = 1'b0;
    int_grant  = 1'b0;
    ldst_grant = 1'b0;
    if (div_elig) begin
      div_grant = 1'b1;
    end else if (mult_elig) begin
      mult_grant = 1'b1;
    end else if (int_elig && ldst_elig) begin
      int_grant  = ~rr_ptr_q;
      ldst_grant = rr_ptr_q;
    end else begin
      int_grant  = int_elig;
      ldst_grant = ldst_elig;
    end
  end

  // Gating with i_rst_n forces the issue strobes low asynchronously while reset is held.
  assign bus.div_issue  = div_grant  & i_rst_n;
  assign bus.mult_issue = mult_grant & i_rst_n;
  assign bus.int_issue  = int_grant  & i_rst_n;
  assign bus.ldst_issue = ldst_grant & i_rst_n;

  always_comb begin
    cdb_rsv_d = cdb_rsv_q >> 1;
    if (int_grant)  cdb_rsv_d = cdb_rsv_d | (RSV_DEPTH'(1) << (INT_LAT - 1));
    if (ldst_grant) cdb_rsv_d = cdb_rsv_d | (RSV_DEPTH'(1) << (LDST_LAT - 1));
    if (mult_grant) cdb_rsv_d = cdb_rsv_d | (RSV_DEPTH'(1) << (MULT_LAT - 1));
    if (div_grant)  cdb_rsv_d = cdb_rsv_d | (RSV_DEPTH'(1) << (DIV_LAT - 1));
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (int_grant)       rr_ptr_d = 1'b1;
    else if (ldst_grant) rr_ptr_d = 1'b0;
  end

  // Busy covers the DIV_LAT-1 cycles after an issue, so the next divide lands DIV_LAT cycles later.
  always_comb begin
    div_cnt_d = div_cnt_q;
    if (div_grant)              div_cnt_d = CNT_W'(DIV_LAT - 1);
    else if (div_cnt_q != '0)   div_cnt_d = div_cnt_q - 1'b1;
    div_busy_d = div_grant | (div_cnt_d != '0);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cdb_rsv_q  <= '0;
      div_cnt_q  <= '0;
      div_busy_q <= 1'b0;
      rr_ptr_q   <= 1'b0;
    end else begin
      cdb_rsv_q  <= cdb_rsv_d;
      div_cnt_q  <= div_cnt_d;
      div_busy_q <= div_busy_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign div_busy = div_busy_q;
  assign cdb_rsv  = cdb_rsv_q;

endmodule

// File: tb/tb_issue_unit.sv
// Bench for issue_unit: directed scenarios plus random traffic, all checked against a
// cycle-indexed CDB ownership model and a divider-free-time model.
module tb_issue_unit;
  localparam int INT_LAT   = 1;
  localparam int LDST_LAT  = 2;
  localparam int MULT_LAT  = 4;
  localparam int DIV_LAT   = 7;
  localparam int RSV_DEPTH = 8;
  localparam int HORIZON   = 4096;

  logic clk = 1'b0;
  logic rst_n;
  logic div_busy;
  logic [RSV_DEPTH-1:0] cdb_rsv;

  always #5 clk = ~clk;

  issue_if bus();

  issue_unit #(
    .INT_LAT(INT_LAT), .LDST_LAT(LDST_LAT), .MULT_LAT(MULT_LAT),
    .DIV_LAT(DIV_LAT), .RSV_DEPTH(RSV_DEPTH)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus),
    .div_busy(div_busy),
    .cdb_rsv (cdb_rsv)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model: absolute cycle number, which future cycles own the CDB, last divide issue time.
  int cyc = 0;
  bit owned [HORIZON];
  int last_div = -100;
  bit rr_ldst_first = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < HORIZON; i++) owned[i] = 1'b0;
    last_div      = -100;
    rr_ldst_first = 1'b0;
  endtask

  function automatic logic [3:0] issues();
    return {bus.div_issue, bus.mult_issue, bus.ldst_issue, bus.int_issue};
  endfunction

  // One clock cycle: r = {div, mult, ldst, int} ready. Entered and left at a falling edge.
  task automatic cycle(input logic [3:0] r);
    logic [3:0] exp_iss;
    logic [RSV_DEPTH-1:0] exp_rsv;
    bit exp_busy, ie, le, me, de;
    bus.int_rdy  = r[0];
    bus.ldst_rdy = r[1];
    bus.mult_rdy = r[2];
    bus.div_rdy  = r[3];
    #1;
    exp_busy = (cyc > last_div) && (cyc < last_div + DIV_LAT);
    ie = r[0] && !owned[cyc + INT_LAT];
    le = r[1] && !owned[cyc + LDST_LAT];
    me = r[2] && !owned[cyc + MULT_LAT];
    de = r[3] && !owned[cyc + DIV_LAT] && !exp_busy;
    if (de)                 exp_iss = 4'b1000;
    else if (me)            exp_iss = 4'b0100;
    else if (ie && le)      exp_iss = rr_ldst_first ? 4'b0010 : 4'b0001;
    else if (ie)            exp_iss = 4'b0001;
    else if (le)            exp_iss = 4'b0010;
    else                    exp_iss = 4'b0000;
    for (int i = 0; i < RSV_DEPTH; i++) exp_rsv[i] = owned[cyc + i];

    check("issue",    32'(issues()), 32'(exp_iss));
    check("onehot0",  32'($onehot0(issues())), 32'd1);
    check("cdb_rsv",  32'(cdb_rsv), 32'(exp_rsv));
    check("div_busy", 32'(div_busy), 32'(exp_busy));

    if (exp_iss[0]) begin owned[cyc + INT_LAT]  = 1'b1; rr_ldst_first = 1'b1; end
    if (exp_iss[1]) begin owned[cyc + LDST_LAT] = 1'b1; rr_ldst_first = 1'b0; end
    if (exp_iss[2]) owned[cyc + MULT_LAT] = 1'b1;
    if (exp_iss[3]) begin owned[cyc + DIV_LAT] = 1'b1; last_div = cyc; end
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reset asserted mid-cycle with every queue ready: effects must be immediate.
  task automatic apply_reset(input int hold);
    rst_n        = 1'b0;
    bus.int_rdy  = 1'b1;
    bus.ldst_rdy = 1'b1;
    bus.mult_rdy = 1'b1;
    bus.div_rdy  = 1'b1;
    #1;
    check("rst_issue",    32'(issues()), 32'd0);
    check("rst_cdb_rsv",  32'(cdb_rsv), 32'd0);
    check("rst_div_busy", 32'(div_busy), 32'd0);
    repeat (hold) @(negedge clk);
    clear_model();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.int_rdy  = 1'b0;
    bus.ldst_rdy = 1'b0;
    bus.mult_rdy = 1'b0;
    bus.div_rdy  = 1'b0;
    @(negedge clk);
    apply_reset(2);

    // Lone int stream: one issue per cycle, slot 0 reserved after each edge.
    repeat (3) begin
      cycle(4'b0001);
      check("int_rsv_after_edge", 32'(cdb_rsv), 32'h01);
    end
    cycle(4'b0000);

    // int/ldst contention alternates starting with int.
    apply_reset(1);
    repeat (4) cycle(4'b0011);

    // mult reservation blocks int for exactly one cycle.
    apply_reset(1);
    cycle(4'b0100);
    repeat (5) cycle(4'b0001);

    // Back-to-back divide requests are spaced DIV_LAT apart.
    apply_reset(1);
    repeat (9) cycle(4'b1000);

    // Everything ready: divider wins, its slot lands at bit DIV_LAT-1.
    apply_reset(1);
    cycle(4'b1111);
    check("all_rdy_rsv", 32'(cdb_rsv), 32'h40);
    cycle(4'b0000);

    // Reset in the middle of a divide, then immediate re-issue.
    apply_reset(1);
    repeat (3) cycle(4'b1000);
    apply_reset(1);
    cycle(4'b1000);
    repeat (3) cycle(4'b0000);

    // Random traffic with occasional resets.
    apply_reset(1);
    repeat (500) begin
      logic [3:0] r;
      for (int b = 0; b < 4; b++) r[b] = ($urandom_range(0, 99) < 55);
      if ($urandom_range(0, 99) == 0) apply_reset(1 + $urandom_range(0, 1));
      cycle(r);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cycle=%0d observed=running expected=finished", cyc);
    $fatal(1, "bench time limit expired");
  end

endmodule
